// File: rtl/scan_chain_driver.sv
// Serial TDR scan-chain initiator: load pattern MSB-first, update, capture, unload response.
// All chain controls are registered; one test takes 2*CHAIN_LEN+3 cycles from start to done.
module scan_chain_driver #(
    parameter int CHAIN_LEN = 128
) (
    input  logic                 i_tck,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [CHAIN_LEN-1:0] i_pattern_in,
    input  logic                 i_tdo,
    output logic                 o_tdi,
    output logic                 o_shift_en,
    output logic                 o_update_en,
    output logic                 o_capture_en,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CHAIN_LEN-1:0] o_response_out
);
    localparam int CW = $clog2(CHAIN_LEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UPDATE,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [CHAIN_LEN-1:0] r_load;
    logic [CHAIN_LEN-1:0] r_collect;
    logic [CHAIN_LEN-1:0] r_response;
    logic                 r_tdi;
    logic                 r_shift_en;
    logic                 r_update_en;
    logic                 r_capture_en;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_last;
    logic [CHAIN_LEN-1:0] w_collect_next;

    assign w_last         = (r_cnt == LAST);
    // tdo is the pre-shift content of the last cell, so the first bit sampled ends up as the MSB.
    assign w_collect_next = {r_collect[CHAIN_LEN-2:0], i_tdo};

    always_ff @(posedge i_tck) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_load       <= '0;
            r_collect    <= '0;
            r_response   <= '0;
            r_tdi        <= 1'b0;
            r_shift_en   <= 1'b0;
            r_update_en  <= 1'b0;
            r_capture_en <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_load     <= {i_pattern_in[CHAIN_LEN-2:0], 1'b0};
                        r_tdi      <= i_pattern_in[CHAIN_LEN-1];
                        r_shift_en <= 1'b1;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_last) begin
                        r_shift_en  <= 1'b0;
                        r_tdi       <= 1'b0;
                        r_update_en <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_UPDATE;
                    end else begin
                        r_tdi  <= r_load[CHAIN_LEN-1];
                        r_load <= {r_load[CHAIN_LEN-2:0], 1'b0};
                        r_cnt  <= r_cnt + CW'(1);
                    end
                end
                S_UPDATE: begin
                    r_update_en  <= 1'b0;
                    r_capture_en <= 1'b1;
                    r_cnt        <= '0;
                    r_state      <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_capture_en <= 1'b0;
                    r_shift_en   <= 1'b1;
                    r_cnt        <= '0;
                    r_state      <= S_UNLOAD;
                end
                S_UNLOAD: begin
                    r_collect <= w_collect_next;
                    if (w_last) begin
                        r_shift_en <= 1'b0;
                        r_response <= w_collect_next;
                        r_done     <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tdi          = r_tdi;
    assign o_shift_en     = r_shift_en;
    assign o_update_en    = r_update_en;
    assign o_capture_en   = r_capture_en;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_response_out = r_response;

endmodule

// File: tb/tb_scan_chain_driver.sv
// Drives scan_chain_driver against a 128-cell TDR chain model whose core loop inverts update into capture.
module tb_scan_chain_driver;
    localparam int CL = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CL-1:0] pat;
    logic          tdo;
    logic          tdi;
    logic          shift_en;
    logic          update_en;
    logic          capture_en;
    logic          busy;
    logic          done;
    logic [CL-1:0] resp;

    always #5 clk = ~clk;

    scan_chain_driver #(.CHAIN_LEN(CL)) dut (
        .i_tck          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_pattern_in   (pat),
        .i_tdo          (tdo),
        .o_tdi          (tdi),
        .o_shift_en     (shift_en),
        .o_update_en    (update_en),
        .o_capture_en   (capture_en),
        .o_busy         (busy),
        .o_done         (done),
        .o_response_out (resp)
    );

    // TDR chain: cell 0 fed by tdi, tdo from cell CL-1, from_core = ~to_core.
    logic [CL-1:0] chain_sr = '0;
    logic [CL-1:0] to_core  = '0;
    assign tdo = chain_sr[CL-1];
    always @(posedge clk) begin
        if (shift_en)        chain_sr <= {chain_sr[CL-2:0], tdi};
        else if (capture_en) chain_sr <= ~to_core;
        if (update_en)       to_core  <= chain_sr;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    int t0      = 0;

    task automatic chk(input string nm, input logic [CL-1:0] act, input logic [CL-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Scoreboard: stimulus pushes expectations, monitor pops on every done pulse.
    logic [CL-1:0] exp_resp_q[$];
    int            exp_cyc_q[$];

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_resp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: done at cycle %0d with nothing expected", cyc - t0);
            end else begin
                chk_int("done_cycle", cyc - t0, exp_cyc_q.pop_front());
                chk("response", resp, exp_resp_q.pop_front());
            end
        end
    end

    // Per-cycle control-timing monitor for the test in flight.
    logic          tracking = 1'b0;
    int            ctl_err  = 0;
    logic [CL-1:0] tdi_seen = '0;
    logic [CL-1:0] to_core_at_cap = '0;

    always @(negedge clk) begin
        if (tracking) begin
            int  rel;
            logic exp_sh;
            rel    = cyc - t0;
            exp_sh = (rel >= 1 && rel <= CL) || (rel >= CL + 3 && rel <= 2 * CL + 2);
            if (shift_en !== exp_sh)                      ctl_err++;
            if (update_en !== (rel == CL + 1))            ctl_err++;
            if (capture_en !== (rel == CL + 2))           ctl_err++;
            if (busy !== (rel >= 1 && rel <= 2 * CL + 3)) ctl_err++;
            if (int'(shift_en) + int'(update_en) + int'(capture_en) > 1) ctl_err++;
            if (rel >= 1 && rel <= CL) tdi_seen[CL - rel] = tdi;
            if (rel == CL + 2) to_core_at_cap = to_core;
        end
    end

    task automatic wait_done();
        while (exp_resp_q.size() != 0 && (cyc - t0) < 400) @(negedge clk);
        if (exp_resp_q.size() != 0) begin
            n_total++;
            $display("FAIL done_timeout: no done by cycle %0d", cyc - t0);
            exp_resp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    task automatic run_test(input logic [CL-1:0] p, input logic second, input logic [CL-1:0] p2);
        @(negedge clk);
        pat      = p;
        start    = 1'b1;
        t0       = cyc;
        ctl_err  = 0;
        tdi_seen = '0;
        tracking = 1'b1;
        exp_resp_q.push_back(~p);
        exp_cyc_q.push_back(2 * CL + 3);
        @(negedge clk);
        start = 1'b0;
        if (second) begin
            while ((cyc - t0) < 40) @(negedge clk);
            pat   = p2;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
        repeat (3) @(negedge clk);
        tracking = 1'b0;
        chk_int("ctl_timing_errors", ctl_err, 0);
        chk("tdi_stream", tdi_seen, p);
        chk("response_hold", resp, ~p);
    endtask

    logic [CL-1:0] p_mix;
    logic [CL-1:0] p_alt;

    initial begin
        p_mix = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        p_alt = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F;
        reset = 1'b1;
        start = 1'b0;
        pat   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_int("reset_ctl", int'({tdi, shift_en, update_en, capture_en, busy, done}), 0);
        chk("reset_response", resp, '0);

        run_test('0, 1'b0, '0);
        run_test(128'h1, 1'b0, '0);
        chk("to_core_after_update", to_core_at_cap, 128'h1);
        run_test(p_mix, 1'b0, '0);
        run_test(p_alt, 1'b1, p_mix);

        // Reset in the middle of LOAD.
        @(negedge clk);
        pat   = p_mix;
        start = 1'b1;
        t0    = cyc;
        exp_resp_q.push_back(~p_mix);
        exp_cyc_q.push_back(2 * CL + 3);
        @(negedge clk);
        start = 1'b0;
        while ((cyc - t0) < 50) @(negedge clk);
        reset = 1'b1;
        exp_resp_q.delete();
        exp_cyc_q.delete();
        @(negedge clk);
        reset = 1'b0;
        chk_int("midload_reset_ctl", int'({tdi, shift_en, update_en, capture_en, busy, done}), 0);
        chk("midload_reset_response", resp, '0);

        run_test(p_alt, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
